// File: rtl/y86_bus_mem.sv
// Byte-addressed program/data store on the y86_seq CPU bus: loads from a byte stream while the
// CPU is held in reset, then serves little-endian unaligned 32-bit reads/writes plus one MMIO port.
module y86_bus_mem #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] MMIO_ADDR = 32'h0000_FFF0,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       bus_A,
  input  logic              bus_RE,
  input  logic              bus_WE,
  input  logic [31:0]       bus_out,
  output logic [31:0]       bus_in,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_rst,
  output logic              out_valid,
  output logic [31:0]       out_data,
  output logic              err,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [7:0]         r_mem [DEPTH];
  logic [ADDR_W-1:0]  r_ld_ptr;
  logic               r_out_valid;
  logic [31:0]        r_out_data;
  logic               r_err;
  logic [CNT_W-1:0]   r_rd_count;
  logic [CNT_W-1:0]   r_wr_count;

  logic [ADDR_W-1:0]  w_lane_addr [4];
  logic [31:0]        w_rd_word;
  logic               w_run;
  logic               w_in_range;
  logic               w_is_mmio;
  logic               w_ld_fire;
  logic               w_rd_ok;
  logic               w_wr_store;
  logic               w_wr_mmio;
  logic               w_err_set;

  // Lane addresses wrap modulo DEPTH so accesses near the top continue at byte 0.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane_addr[gi]         = bus_A[ADDR_W-1:0] + ADDR_W'(gi);
      assign w_rd_word[8*gi +: 8]    = r_mem[w_lane_addr[gi]];
    end
  endgenerate

  assign w_run      = (r_state == S_RUN);
  assign w_in_range = (bus_A[31:ADDR_W] == '0);
  assign w_is_mmio  = (bus_A == MMIO_ADDR);
  assign w_ld_fire  = (r_state == S_LOAD) && ld_valid;
  assign w_rd_ok    = w_run && bus_RE && !bus_WE && w_in_range;
  assign w_wr_mmio  = w_run && bus_WE && w_is_mmio;
  assign w_wr_store = w_run && bus_WE && !w_is_mmio && w_in_range;
  assign w_err_set  = w_run && ((bus_RE && !w_in_range) ||
                                (bus_WE && !w_is_mmio && !w_in_range) ||
                                (bus_RE && bus_WE));

  assign bus_in    = w_rd_ok ? w_rd_word : 32'h0;
  assign ld_ready  = (r_state == S_LOAD);
  assign cpu_rst   = (r_state == S_LOAD);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign err       = r_err;
  assign rd_count  = r_rd_count;
  assign wr_count  = r_wr_count;

  always_comb begin
    w_state_next = r_state;
    if (w_ld_fire && (ld_last || r_ld_ptr == '1)) begin
      w_state_next = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_LOAD;
      r_ld_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= 32'h0;
      r_err       <= 1'b0;
      r_rd_count  <= '0;
      r_wr_count  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_out_valid <= w_wr_mmio;
      if (w_ld_fire) begin
        r_ld_ptr <= r_ld_ptr + 1'b1;
      end
      if (w_wr_mmio) begin
        r_out_data <= bus_out;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (w_rd_ok && r_rd_count != '1) begin
        r_rd_count <= r_rd_count + 1'b1;
      end
      if ((w_wr_mmio || w_wr_store) && r_wr_count != '1) begin
        r_wr_count <= r_wr_count + 1'b1;
      end
    end
  end

  // Store contents survive reset; writes are simply suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && w_ld_fire) begin
      r_mem[r_ld_ptr] <= ld_data;
    end
    if (!rst && w_wr_store) begin
      for (int k = 0; k < 4; k++) begin
        r_mem[w_lane_addr[k]] <= bus_out[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_y86_bus_mem.sv
// Directed bench for y86_bus_mem: a behavioural memory/loader model is compared every cycle,
// and literal expectations queued by the stimulus pin the model to hand-computed values.
module tb_y86_bus_mem;

  localparam logic [31:0] MMIO = 32'h0000_FFF0;

  logic        clk;
  logic        rst;
  logic [31:0] bus_A;
  logic        bus_RE;
  logic        bus_WE;
  logic [31:0] bus_out;
  logic [31:0] bus_in;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        cpu_rst;
  logic        out_valid;
  logic [31:0] out_data;
  logic        err;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  y86_bus_mem #(.ADDR_W(10), .MMIO_ADDR(MMIO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .bus_A(bus_A), .bus_RE(bus_RE), .bus_WE(bus_WE), .bus_out(bus_out), .bus_in(bus_in),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .cpu_rst(cpu_rst), .out_valid(out_valid), .out_data(out_data), .err(err),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a 1 KiB byte array plus the handful of visible status values.
  logic [7:0]  m_mem [1024];
  bit          m_run;
  int          m_ptr;
  logic [15:0] m_rd, m_wr;
  bit          m_err, m_ov;
  logic [31:0] m_od;

  initial begin
    for (int i = 0; i < 1024; i++) m_mem[i] = 8'h00;
    m_run = 0; m_ptr = 0; m_rd = 0; m_wr = 0; m_err = 0; m_ov = 0; m_od = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_run <= 0; m_ptr <= 0; m_rd <= 0; m_wr <= 0; m_err <= 0; m_ov <= 0; m_od <= 0;
    end else if (!m_run) begin
      m_ov <= 0;
      if (ld_valid) begin
        m_mem[m_ptr] <= ld_data;
        m_ptr <= m_ptr + 1;
        if (ld_last || m_ptr == 1023) m_run <= 1;
      end
    end else begin
      m_ov <= bus_WE && (bus_A == MMIO);
      if (bus_WE && bus_A == MMIO) begin
        m_od <= bus_out;
        if (m_wr != 16'hFFFF) m_wr <= m_wr + 16'd1;
      end else if (bus_WE && bus_A < 1024) begin
        for (int k = 0; k < 4; k++) m_mem[int'((bus_A + k) % 1024)] <= bus_out[8*k +: 8];
        if (m_wr != 16'hFFFF) m_wr <= m_wr + 16'd1;
      end
      if (bus_RE && !bus_WE && bus_A < 1024 && m_rd != 16'hFFFF) m_rd <= m_rd + 16'd1;
      if ((bus_RE && bus_A >= 1024) || (bus_WE && bus_A != MMIO && bus_A >= 1024) || (bus_RE && bus_WE))
        m_err <= 1;
    end
  end

  function automatic logic [31:0] exp_bus_in();
    logic [31:0] w;
    w = 32'h0;
    if (m_run && bus_RE && !bus_WE && bus_A < 1024) begin
      for (int k = 0; k < 4; k++) w[8*k +: 8] = m_mem[int'((bus_A + k) % 1024)];
    end
    return w;
  endfunction

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
  } lit_t;
  lit_t lit_q [$];

  function automatic logic [31:0] get_sig(int s);
    case (s)
      0: return bus_in;
      1: return {31'b0, ld_ready};
      2: return {31'b0, cpu_rst};
      3: return {31'b0, out_valid};
      4: return out_data;
      5: return {31'b0, err};
      6: return {16'b0, rd_count};
      default: return {16'b0, wr_count};
    endcase
  endfunction

  int  n_checks = 0;
  int  n_errors = 0;
  bit  chk_en   = 0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("bus_in",    bus_in,              exp_bus_in());
      chk("ld_ready",  {31'b0, ld_ready},   {31'b0, !m_run});
      chk("cpu_rst",   {31'b0, cpu_rst},    {31'b0, !m_run});
      chk("out_valid", {31'b0, out_valid},  {31'b0, m_ov});
      chk("out_data",  out_data,            m_od);
      chk("err",       {31'b0, err},        {31'b0, m_err});
      chk("rd_count",  {16'b0, rd_count},   {16'b0, m_rd});
      chk("wr_count",  {16'b0, wr_count},   {16'b0, m_wr});
      while (lit_q.size() > 0) begin
        lit_t l;
        l = lit_q.pop_front();
        chk(l.name, get_sig(l.sig), l.exp);
      end
    end
  end

  task automatic lit(string n, int s, logic [31:0] e);
    lit_t l;
    l.name = n; l.sig = s; l.exp = e;
    lit_q.push_back(l);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus_RE = 0; bus_WE = 0; bus_A = 0; bus_out = 0;
  endtask

  task automatic do_reset();
    rst = 1; ld_valid = 0; ld_last = 0; idle_bus();
    tick();
    rst = 0;
    $display("reset: ld_ready=%0b cpu_rst=%0b err=%0b", ld_ready, cpu_rst, err);
  endtask

  task automatic load_byte(logic [7:0] d, logic last);
    ld_valid = 1; ld_data = d; ld_last = last;
    tick();
    ld_valid = 0; ld_last = 0;
    $display("load 0x%02h last=%0b -> ld_ready=%0b cpu_rst=%0b", d, last, ld_ready, cpu_rst);
  endtask

  task automatic cpu_read(logic [31:0] a, logic [31:0] exp);
    idle_bus(); bus_RE = 1; bus_A = a;
    lit($sformatf("read_0x%08h", a), 0, exp);
    tick();
    $display("read  A=0x%08h expect 0x%08h", a, exp);
    idle_bus();
  endtask

  task automatic cpu_write(logic [31:0] a, logic [31:0] d, logic re);
    idle_bus(); bus_WE = 1; bus_RE = re; bus_A = a; bus_out = d;
    if (re) lit("rewe_bus_in", 0, 32'h0);
    tick();
    $display("write A=0x%08h D=0x%08h RE=%0b", a, d, re);
    idle_bus();
  endtask

  initial begin
    rst = 1; ld_valid = 0; ld_data = 0; ld_last = 0; idle_bus();
    tick(); tick();
    chk_en = 1;
    rst = 0;
    lit("rst_ld_ready", 1, 1); lit("rst_cpu_rst", 2, 1); lit("rst_err", 5, 0);
    lit("rst_rd_count", 6, 0); lit("rst_wr_count", 7, 0); lit("rst_out_data", 4, 0);

    // Pre-zero the whole store; the final byte at DEPTH-1 ends the load without ld_last.
    ld_valid = 1; ld_data = 8'h00; ld_last = 0;
    for (int i = 0; i < 1024; i++) tick();
    ld_valid = 0;
    $display("zero-fill 1024 bytes -> cpu_rst=%0b", cpu_rst);
    lit("fill_end_cpu_rst", 2, 0); lit("fill_end_ld_ready", 1, 0);
    tick();

    // Test 1
    do_reset();
    load_byte(8'h01, 0);
    lit("t1_still_loading", 2, 1);
    load_byte(8'hF4, 1);
    lit("t1_ld_ready", 1, 0); lit("t1_cpu_rst", 2, 0);
    cpu_read(32'h0, 32'h0000_F401);

    // Test 2
    do_reset();
    for (int i = 0; i < 8; i++) load_byte(8'(i), (i == 7));
    cpu_read(32'h5, 32'h0007_0605);

    // Test 3: write straddling the top of the store
    cpu_write(32'h3FE, 32'hAABB_CCDD, 0);
    cpu_read(32'h3FE, 32'hAABB_CCDD);
    cpu_read(32'h0, 32'h0302_AABB);

    // Test 4: MMIO
    do_reset();
    load_byte(8'h55, 1);
    cpu_write(MMIO, 32'h1234_5678, 0);
    lit("t4_out_valid", 3, 1); lit("t4_out_data", 4, 32'h1234_5678); lit("t4_wr_count", 7, 1);
    tick();
    lit("t4_out_valid_drop", 3, 0);
    cpu_read(32'h0, 32'h0302_AA55);

    // Test 5: out-of-range read, then RE+WE together
    cpu_read(32'h400, 32'h0);
    lit("t5_err", 5, 1); lit("t5_rd_count", 6, 1);
    cpu_write(32'h10, 32'hCAFE_BABE, 1);
    lit("t5_wr_count", 7, 2); lit("t5_rd_count2", 6, 1); lit("t5_err2", 5, 1);
    cpu_read(32'h10, 32'hCAFE_BABE);

    // Test 6: reset in the middle of a load
    do_reset();
    load_byte(8'h11, 0); load_byte(8'h22, 0); load_byte(8'h33, 0);
    do_reset();
    lit("t6_ld_ready", 1, 1); lit("t6_cpu_rst", 2, 1); lit("t6_err", 5, 0);
    load_byte(8'h99, 1);
    lit("t6_run", 2, 0);
    cpu_read(32'h0, 32'h0333_2299);

    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
